fft_result_reader: RTL and testbench
====================================

Name: fft_result_reader

Overview:
- Sink for the FFT core output stream (fin_en / fin_cnt / fin_re / fin_im, the core's dout_* bus).
- Captures one 2^N-bin frame into an internal RAM at natural-order addresses, with optional bit-reverse of the index, and tracks the peak bin by |re|+|im|.
- Replays the frame in ascending bin order over a valid/ready handshake toward the host/UART side.
- Sits directly after the FFT top module in the FPGA design.

Parameters:
- width, 16, bit width of signed re/im samples.
- N, 9, log2 of FFT length; frame = 2^N bins.
- BITREV, 1, 1 = fin_cnt arrives bit-reversed and is reversed to form the RAM address; 0 = fin_cnt used as-is.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- areset  in  1  reset, synchronous, active-high.
- fin_en  in  1  input bin valid, one bin per cycle while high.
- fin_cnt  in  N  input bin index as emitted by the FFT.
- fin_re  in  width  signed real part.
- fin_im  in  width  signed imaginary part.
- busy  out  1  high outside IDLE.
- frame_drop  out  1  one-cycle pulse: fin_en seen while in DRAIN; that bin is discarded.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accept.
- out_idx  out  N  natural-order bin index of the output bin.
- out_re  out  width  signed real part of the output bin.
- out_im  out  width  signed imaginary part of the output bin.
- out_last  out  1  high with the bin where out_idx = 2^N-1.
- peak_valid  out  1  high from end of CAPTURE until the next frame's first accepted bin.
- peak_idx  out  N  natural index of the maximum-magnitude bin.
- peak_mag  out  width+1  unsigned |re|+|im| of that bin.

Behaviour:
- Reset (areset=1 at clk edge) returns to IDLE. All outputs are 0, the capture counter is 0 and peak registers are 0. RAM contents are don't-care. Reset mid-CAPTURE or mid-DRAIN aborts the frame without completing the handshake.
- Address: addr = BITREV ? bitreverse(fin_cnt) : fin_cnt.
- States are IDLE, CAPTURE and DRAIN.
- IDLE -> CAPTURE on fin_en=1. That bin is written the same cycle, the counter becomes 1 and the peak registers are loaded from it (peak_valid clears).
- CAPTURE: each fin_en=1 cycle writes RAM[addr] and increments the counter. Gaps (fin_en=0) are allowed and simply pause capture. Repeated addresses overwrite, but the counter still counts them.
- CAPTURE -> DRAIN in the cycle after the 2^N-th accepted bin. peak_valid rises in that same cycle.
- Magnitude: |re|+|im| in width+1 bits; abs(-2^(width-1)) = 2^(width-1), with no saturation.
- Peak update: a new bin replaces the peak if mag > peak_mag, or if mag == peak_mag and addr < peak_idx (ties go to the lower natural index).
- DRAIN uses a synchronous-read RAM plus an output register with a one-entry prefetch, so back-to-back transfers sustain 1 bin/cycle.
  - out_valid rises 2 cycles after DRAIN entry, with out_idx = 0.
  - Transfer happens when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_idx/out_re/out_im/out_last hold stable.
- After the transfer with out_last=1: out_valid drops next cycle and the state goes to IDLE. peak_* remain valid.
- fin_en=1 during DRAIN: the bin is not written, frame_drop pulses 1 cycle and the state is unchanged.
- Simultaneous final DRAIN transfer and fin_en: the state goes to IDLE, the bin is dropped with frame_drop; the next fin_en starts a frame.
- Write and read of the same address in one cycle cannot occur, because the two states are exclusive.

Test Plan:
- BITREV=0, N=9: feed bins fin_cnt=k, re=k, im=-k contiguously, out_ready=1. Required: out_idx 0..511 in order, out_re=k, out_im=-k, out_last only at 511, peak_idx=511, peak_mag=1022, first out_valid 2 cycles after DRAIN entry.
- BITREV=1: feed fin_cnt=i with re equal to bitreverse9(i). Required: out_re equals out_idx for all 512 outputs.
- Backpressure: toggle out_ready 1,0,0,1 repeatedly. Required: no bin lost or duplicated, data stable during stalls, exactly 512 transfers.
- Peak tie and extreme values: bin 5 = (-32768, 0) and bin 3 = (0, -32768), all others 0. Required: peak_idx=3, peak_mag=32768.
- Input gaps plus overrun: insert 10-cycle fin_en gaps mid-frame, then assert fin_en during DRAIN. Required: capture completes after 512 accepted bins, frame_drop pulses once per extra bin, replayed data unchanged.
- Reset mid-DRAIN after 100 transfers. Required: next cycle out_valid=0, busy=0, peak_valid=0; a new frame then captures and replays correctly.

Source files
------------

// File: rtl/fft_result_reader.sv
// Captures one 2^N-bin FFT output frame into RAM, tracks the peak |re|+|im| bin, and
// replays the frame in natural bin order over a valid/ready stream with one-entry prefetch.
module fft_result_reader #(
    parameter int width  = 16,
    parameter int N      = 9,
    parameter bit BITREV = 1'b1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             fin_en,
    input  logic [N-1:0]     fin_cnt,
    input  logic [width-1:0] fin_re,
    input  logic [width-1:0] fin_im,
    output logic             busy,
    output logic             frame_drop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_idx,
    output logic [width-1:0] out_re,
    output logic [width-1:0] out_im,
    output logic             out_last,
    output logic             peak_valid,
    output logic [N-1:0]     peak_idx,
    output logic [width:0]   peak_mag
);

    localparam int           DEPTH    = 1 << N;
    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N-1:0]       cnt_q, cnt_d;
    logic               peak_valid_q, peak_valid_d;
    logic [N-1:0]       peak_idx_q, peak_idx_d;
    logic [width:0]     peak_mag_q, peak_mag_d;
    logic               frame_drop_q, frame_drop_d;
    logic [N-1:0]       rd_ptr_q, rd_ptr_d;
    logic               rd_done_q, rd_done_d;
    logic               pf_valid_q, pf_valid_d;
    logic [N-1:0]       pf_idx_q, pf_idx_d;
    logic               out_valid_q, out_valid_d;
    logic [N-1:0]       out_idx_q, out_idx_d;
    logic [width-1:0]   out_re_q, out_re_d;
    logic [width-1:0]   out_im_q, out_im_d;

    logic [2*width-1:0] ram [DEPTH];
    logic [2*width-1:0] rd_data_q;

    logic [N-1:0]       wr_addr;
    logic [width:0]     fin_mag;
    logic               cap_en;
    logic               in_drain;
    logic               last_bin;
    logic               xfer;
    logic               out_free;
    logic               pf_move;
    logic               rd_en;
    logic               peak_better;
    logic               last_xfer;

    function automatic logic [N-1:0] bit_reverse(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i] = v[N-1-i];
        end
        return r;
    endfunction

    // Two's-complement magnitude; the most negative value maps to 2^(width-1) unsigned.
    function automatic logic [width-1:0] abs_val(input logic [width-1:0] v);
        return v[width-1] ? (~v + width'(1)) : v;
    endfunction

    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (here by unconditional assignment, below by defaults first) so no latch is inferred.
    always_comb begin
        wr_addr     = BITREV ? bit_reverse(fin_cnt) : fin_cnt;
        fin_mag     = {1'b0, abs_val(fin_re)} + {1'b0, abs_val(fin_im)};
        cap_en      = fin_en && (state_q != S_DRAIN);
        in_drain    = (state_q == S_DRAIN);
        last_bin    = fin_en && (state_q == S_CAPTURE) && (cnt_q == LAST_IDX);
        xfer        = out_valid_q && out_ready;
        out_free    = !out_valid_q || xfer;
        pf_move     = pf_valid_q && out_free;
        rd_en       = in_drain && !rd_done_q && (!pf_valid_q || pf_move);
        peak_better = (fin_mag > peak_mag_q) ||
                      ((fin_mag == peak_mag_q) && (wr_addr < peak_idx_q));
        last_xfer   = xfer && (out_idx_q == LAST_IDX);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (fin_en)    state_d = S_CAPTURE;
            S_CAPTURE: if (last_bin)  state_d = S_DRAIN;
            S_DRAIN:   if (last_xfer) state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        out_last = out_valid_q && (out_idx_q == LAST_IDX);
    end

    always_comb begin
        cnt_d        = cnt_q;
        peak_valid_d = peak_valid_q;
        peak_idx_d   = peak_idx_q;
        peak_mag_d   = peak_mag_q;
        frame_drop_d = in_drain && fin_en;
        rd_ptr_d     = rd_ptr_q;
        rd_done_d    = rd_done_q;
        pf_valid_d   = pf_valid_q;
        pf_idx_d     = pf_idx_q;
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_re_d     = out_re_q;
        out_im_d     = out_im_q;

        if (cap_en) begin
            cnt_d = (state_q == S_IDLE) ? N'(1) : cnt_q + N'(1);
            if ((state_q == S_IDLE) || peak_better) begin
                peak_idx_d = wr_addr;
                peak_mag_d = fin_mag;
            end
        end

        if (cap_en && (state_q == S_IDLE)) begin
            peak_valid_d = 1'b0;
        end else if (last_bin) begin
            peak_valid_d = 1'b1;
        end

        // Read data lands in rd_data_q, which doubles as the prefetch slot in front of
        // the output register; a read is issued only when that slot will be free.
        if (in_drain) begin
            if (rd_en) begin
                rd_ptr_d  = rd_ptr_q + N'(1);
                rd_done_d = (rd_ptr_q == LAST_IDX);
                pf_idx_d  = rd_ptr_q;
            end
            pf_valid_d = rd_en || (pf_valid_q && !pf_move);
            if (pf_move) begin
                out_valid_d = 1'b1;
                out_idx_d   = pf_idx_q;
                out_re_d    = rd_data_q[2*width-1:width];
                out_im_d    = rd_data_q[width-1:0];
            end else if (xfer) begin
                out_valid_d = 1'b0;
            end
        end else begin
            rd_ptr_d    = '0;
            rd_done_d   = 1'b0;
            pf_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            cnt_q        <= '0;
            peak_valid_q <= 1'b0;
            peak_idx_q   <= '0;
            peak_mag_q   <= '0;
            frame_drop_q <= 1'b0;
            rd_ptr_q     <= '0;
            rd_done_q    <= 1'b0;
            pf_valid_q   <= 1'b0;
            pf_idx_q     <= '0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_re_q     <= '0;
            out_im_q     <= '0;
        end else begin
            cnt_q        <= cnt_d;
            peak_valid_q <= peak_valid_d;
            peak_idx_q   <= peak_idx_d;
            peak_mag_q   <= peak_mag_d;
            frame_drop_q <= frame_drop_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_done_q    <= rd_done_d;
            pf_valid_q   <= pf_valid_d;
            pf_idx_q     <= pf_idx_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_re_q     <= out_re_d;
            out_im_q     <= out_im_d;
        end
    end

    // NOTE: the frame RAM has no reset; its contents are only read after a full
    // capture, and leaving it unreset lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            ram[wr_addr] <= {fin_re, fin_im};
        end
        if (rd_en) begin
            rd_data_q <= ram[rd_ptr_q];
        end
    end

    assign frame_drop = frame_drop_q;
    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_re     = out_re_q;
    assign out_im     = out_im_q;
    assign peak_valid = peak_valid_q;
    assign peak_idx   = peak_idx_q;
    assign peak_mag   = peak_mag_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Randomized bench for fft_result_reader: one natural-order and one bit-reversed instance,
// checked against an array model of the frame RAM and an argmax model of the peak bin.
module tb_fft_result_reader;

    localparam int W     = 16;
    localparam int NB    = 9;
    localparam int FRAME = 1 << NB;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          fin_en = 1'b0;
    logic [NB-1:0] fin_cnt = '0;
    logic [W-1:0]  fin_re = '0;
    logic [W-1:0]  fin_im = '0;
    logic          out_ready = 1'b0;
    int            sel = 0;

    always #5 clk = ~clk;

    logic          a_fin_en, b_fin_en, a_out_ready, b_out_ready;
    logic          a_busy, a_frame_drop, a_out_valid, a_out_last, a_peak_valid;
    logic          b_busy, b_frame_drop, b_out_valid, b_out_last, b_peak_valid;
    logic [NB-1:0] a_out_idx, a_peak_idx, b_out_idx, b_peak_idx;
    logic [W-1:0]  a_out_re, a_out_im, b_out_re, b_out_im;
    logic [W:0]    a_peak_mag, b_peak_mag;

    assign a_fin_en    = fin_en && (sel == 0);
    assign b_fin_en    = fin_en && (sel == 1);
    assign a_out_ready = out_ready && (sel == 0);
    assign b_out_ready = out_ready && (sel == 1);

    fft_result_reader #(.width(W), .N(NB), .BITREV(1'b0)) u_dut_nat (
        .clk(clk), .areset(areset), .fin_en(a_fin_en), .fin_cnt(fin_cnt),
        .fin_re(fin_re), .fin_im(fin_im), .busy(a_busy), .frame_drop(a_frame_drop),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx),
        .out_re(a_out_re), .out_im(a_out_im), .out_last(a_out_last),
        .peak_valid(a_peak_valid), .peak_idx(a_peak_idx), .peak_mag(a_peak_mag)
    );

    fft_result_reader #(.width(W), .N(NB), .BITREV(1'b1)) u_dut_rev (
        .clk(clk), .areset(areset), .fin_en(b_fin_en), .fin_cnt(fin_cnt),
        .fin_re(fin_re), .fin_im(fin_im), .busy(b_busy), .frame_drop(b_frame_drop),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
        .out_re(b_out_re), .out_im(b_out_im), .out_last(b_out_last),
        .peak_valid(b_peak_valid), .peak_idx(b_peak_idx), .peak_mag(b_peak_mag)
    );

    logic                 o_busy, o_valid, o_last, o_peak_valid;
    logic [NB-1:0]        o_idx, o_peak_idx;
    logic signed [W-1:0]  o_re, o_im;
    logic [W:0]           o_peak_mag;

    assign o_busy       = (sel == 0) ? a_busy       : b_busy;
    assign o_valid      = (sel == 0) ? a_out_valid  : b_out_valid;
    assign o_last       = (sel == 0) ? a_out_last   : b_out_last;
    assign o_peak_valid = (sel == 0) ? a_peak_valid : b_peak_valid;
    assign o_idx        = (sel == 0) ? a_out_idx    : b_out_idx;
    assign o_peak_idx   = (sel == 0) ? a_peak_idx   : b_peak_idx;
    assign o_re         = (sel == 0) ? a_out_re     : b_out_re;
    assign o_im         = (sel == 0) ? a_out_im     : b_out_im;
    assign o_peak_mag   = (sel == 0) ? a_peak_mag   : b_peak_mag;

    int n_checks = 0;
    int n_bad    = 0;
    int drop_seen = 0;

    always @(negedge clk) begin
        if (a_frame_drop || b_frame_drop) drop_seen <= drop_seen + 1;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame RAM contents per instance and the expected peak.
    int exp_re [2][FRAME];
    int exp_im [2][FRAME];
    int f_cnt [FRAME];
    int f_re  [FRAME];
    int f_im  [FRAME];
    int exp_pk_idx;
    int exp_pk_mag;

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < NB; i++) r |= ((v >> i) & 1) << (NB - 1 - i);
        return r;
    endfunction

    function automatic int addr_of(input int s, input int cnt);
        return (s == 1) ? bitrev(cnt) : cnt;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rand_s();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic update_model(input int s);
        int best = -1;
        for (int i = 0; i < FRAME; i++) begin
            int a = addr_of(s, f_cnt[i]);
            exp_re[s][a] = f_re[i];
            exp_im[s][a] = f_im[i];
            if (iabs(f_re[i]) + iabs(f_im[i]) > best) best = iabs(f_re[i]) + iabs(f_im[i]);
        end
        exp_pk_mag = best;
        exp_pk_idx = FRAME;
        for (int i = 0; i < FRAME; i++) begin
            int a = addr_of(s, f_cnt[i]);
            if ((iabs(f_re[i]) + iabs(f_im[i]) == best) && (a < exp_pk_idx)) exp_pk_idx = a;
        end
    endtask

    task automatic gen_frame(input int kind);
        for (int i = 0; i < FRAME; i++) begin
            f_cnt[i] = i;
            f_re[i]  = rand_s();
            f_im[i]  = rand_s();
            case (kind)
                0: begin f_re[i] = i; f_im[i] = -i; end
                1: f_re[i] = bitrev(i);
                2: begin f_re[i] = (i == 5) ? -32768 : 0; f_im[i] = (i == 3) ? -32768 : 0; end
                4: f_cnt[i] = int'($urandom_range(0, FRAME - 1));
                default: ;
            endcase
        end
        if (kind == 3) begin
            for (int i = FRAME - 1; i > 0; i--) begin
                int j = int'($urandom_range(0, i));
                int t = f_cnt[i];
                f_cnt[i] = f_cnt[j];
                f_cnt[j] = t;
            end
        end
    endtask

    // Entered and left at posedge+1; the last bin's edge leaves the DUT in DRAIN cycle 0.
    task automatic feed_frame(input bit gaps);
        for (int i = 0; i < FRAME; i++) begin
            if (gaps && (i == 100 || i == 300)) begin
                fin_en = 1'b0;
                repeat (10) begin @(posedge clk); #1; end
            end
            fin_en  = 1'b1;
            fin_cnt = NB'(f_cnt[i]);
            fin_re  = W'(f_re[i]);
            fin_im  = W'(f_im[i]);
            @(posedge clk); #1;
        end
        fin_en = 1'b0;
    endtask

    task automatic drain_frame(input int s, input int mode, input bit overrun, input int stop_after);
        int  xfers = 0;
        int  cyc = 0;
        int  first_valid = -1;
        int  drops_exp = 0;
        int  drops0 = drop_seen;
        bit  stalled = 1'b0;
        bit  done = 1'b0;
        while (!done && cyc < 8000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            fin_en = overrun && (cyc % 37 == 20);
            fin_cnt = NB'($urandom_range(0, FRAME - 1));
            fin_re  = W'(rand_s());
            @(negedge clk);
            if (cyc == 0) begin
                check("entry_busy", o_busy, 1);
                check("entry_peak_valid", o_peak_valid, 1);
                check("entry_out_valid", o_valid, 0);
                check("peak_idx", o_peak_idx, exp_pk_idx);
                check("peak_mag", o_peak_mag, exp_pk_mag);
            end
            if (overrun && o_valid && out_ready && o_last) fin_en = 1'b1;
            if (fin_en) drops_exp++;
            if (stalled) check("stall_hold_valid", o_valid, 1);
            if (o_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    check("first_valid_cycle", cyc, 2);
                end
                check("out_idx", o_idx, xfers);
                check("out_re", o_re, exp_re[s][xfers]);
                check("out_im", o_im, exp_im[s][xfers]);
                check("out_last", o_last, (xfers == FRAME - 1));
                if (out_ready) begin
                    xfers++;
                    if (xfers == FRAME || xfers == stop_after) done = 1'b1;
                end
            end
            stalled = o_valid && !out_ready;
            @(posedge clk); #1;
            cyc++;
        end
        fin_en    = 1'b0;
        out_ready = 1'b0;
        check("drain_completed", done, 1);
        if (stop_after == 0) begin
            @(negedge clk);
            check("end_out_valid", o_valid, 0);
            check("end_busy", o_busy, 0);
            check("end_peak_valid", o_peak_valid, 1);
            check("end_peak_idx", o_peak_idx, exp_pk_idx);
            check("end_peak_mag", o_peak_mag, exp_pk_mag);
            repeat (3) @(posedge clk);
            #1;
            check("frame_drop_count", drop_seen - drops0, drops_exp);
        end
    endtask

    task automatic run_frame(input int s, input int kind, input bit gaps, input int mode, input bit overrun);
        sel = s;
        gen_frame(kind);
        update_model(s);
        feed_frame(gaps);
        drain_frame(s, mode, overrun, 0);
    endtask

    initial begin
        areset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        @(negedge clk);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_last", a_out_last, 0);
        check("rst_a_drop", a_frame_drop, 0);
        check("rst_a_peak_valid", a_peak_valid, 0);
        check("rst_a_peak_mag", a_peak_mag, 0);
        check("rst_b_busy", b_busy, 0);
        check("rst_b_valid", b_out_valid, 0);
        check("rst_b_peak_idx", b_peak_idx, 0);
        check("rst_b_peak_mag", b_peak_mag, 0);
        @(posedge clk); #1;

        run_frame(0, 0, 1'b0, 0, 1'b0);   // ramp, natural order, full throughput
        run_frame(1, 1, 1'b0, 0, 1'b0);   // bit-reversed input index
        run_frame(1, 3, 1'b0, 1, 1'b0);   // permuted order, 1,0,0,1 backpressure
        run_frame(0, 2, 1'b0, 0, 1'b0);   // tie between extreme-value bins
        run_frame(1, 3, 1'b1, 2, 1'b1);   // input gaps plus overrun during replay
        run_frame(0, 4, 1'b1, 2, 1'b1);   // duplicate indices, random data

        // Reset during replay, then a fresh frame.
        sel = 1;
        gen_frame(3);
        update_model(1);
        feed_frame(1'b0);
        drain_frame(1, 0, 1'b0, 100);
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", o_valid, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_peak_valid", o_peak_valid, 0);
        @(posedge clk); #1;
        run_frame(1, 3, 1'b0, 2, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
